febjtag_gen: RTL

FEBJTAG_GEN -- requirements
Module: febjtag_gen

---
 rtl/febjtag_pkg.sv | 49 ++++
 rtl/febjtag_tck_div.sv | 53 +++++
 rtl/febjtag_gen.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/febjtag_pkg.sv
// ---------------------------------------------------------------------------
// febjtag_pkg
// Shared definitions for the front-end-board JTAG sequence generator.
//   state_t    : sequencer FSM states
//   mode_t     : MODE input encodings
//   *_TMS      : TMS patterns for header, trailer and TAP reset. Bit 0 is
//                the value of the first TCK pulse.
//   pat_bit()  : selects one bit of a pattern by a run-time index
// Optional feature macro used by the generator: FEBJTAG_READBACK_EN
// ---------------------------------------------------------------------------
package febjtag_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HEAD  = 3'd1,
        ST_SHIFT = 3'd2,
        ST_TAIL  = 3'd3,
        ST_TRST  = 3'd4,
        ST_NOP   = 3'd5,
        ST_FIN   = 3'd6
    } state_t;

    typedef enum logic [1:0] {
        MODE_DATA  = 2'd0,
        MODE_INSTR = 2'd1,
        MODE_TRST  = 2'd2,
        MODE_RSVD  = 2'd3
    } mode_t;

    localparam int HDR_LEN  = 5;
    localparam int TRL_LEN  = 2;
    localparam int TRST_LEN = 6;

    // Idle -> Select-DR -> Capture-DR -> Shift-DR sequences, first pulse in bit 0
    localparam logic [HDR_LEN-1:0]  HDR_DATA_TMS  = 5'b00100;
    localparam logic [HDR_LEN-1:0]  HDR_INSTR_TMS = 5'b00110;
    // Update -> Run-Test/Idle
    localparam logic [TRL_LEN-1:0]  TRL_TMS       = 2'b01;
    // Five ones force Test-Logic-Reset from any state, then park in Idle
    localparam logic [TRST_LEN-1:0] TRST_TMS      = 6'b011111;

    // Shift-based select keeps index widths independent of pattern length
    function automatic logic pat_bit(input logic [7:0] pat, input logic [7:0] idx);
        logic [7:0] shifted;
        shifted = pat >> idx;
        return shifted[0];
    endfunction

endpackage

// File: rtl/febjtag_tck_div.sv
// ---------------------------------------------------------------------------
// febjtag_tck_div
// TCK generator: while RUN is high, TCK is TCK_HALF cycles low followed by
// TCK_HALF cycles high, starting low. RUN low parks TCK low and rewinds the
// phase so the next run starts with a full low half-period.
// Ports:
//   CLK   in   block clock
//   RST_B in   asynchronous active-low reset
//   RUN   in   enable pulse generation
//   TCK   out  registered TCK
//   RISE  out  high in the cycle whose closing CLK edge raises TCK
//   FALL  out  high in the cycle whose closing CLK edge lowers TCK
// ---------------------------------------------------------------------------
module febjtag_tck_div #(
    parameter int TCK_HALF = 1
) (
    input  logic CLK,
    input  logic RST_B,
    input  logic RUN,
    output logic TCK,
    output logic RISE,
    output logic FALL
);

    localparam logic [7:0] HALF_LAST = 8'(TCK_HALF - 1);

    logic [7:0] half_cnt;
    logic       tck_q;
    logic       half_end;

    assign half_end = (half_cnt == HALF_LAST);

    // Half-period counter; TCK toggles at the end of every half period
    always_ff @(posedge CLK or negedge RST_B) begin
        if (!RST_B) begin
            half_cnt <= '0;
            tck_q    <= 1'b0;
        end else if (!RUN) begin
            half_cnt <= '0;
            tck_q    <= 1'b0;
        end else if (half_end) begin
            half_cnt <= '0;
            tck_q    <= ~tck_q;
        end else begin
            half_cnt <= half_cnt + 8'd1;
        end
    end

    assign TCK  = tck_q;
    assign RISE = RUN & half_end & ~tck_q;
    assign FALL = RUN & half_end &  tck_q;

endmodule

// File: rtl/febjtag_gen.sv
// ---------------------------------------------------------------------------
// febjtag_gen
// JTAG sequence generator for up to 16 front-end channels sharing TMS/TDI.
// One START runs: optional header -> shift of NBITS+1 bits -> optional
// trailer, or a TAP reset sequence (MODE=2), or an empty operation (MODE=3).
// Ports:
//   CLK, RST_B      clock, asynchronous active-low reset
//   START           request pulse, taken only while BUSY is low
//   MODE[1:0]       0 data, 1 instruction, 2 TAP reset, 3 reserved (no TCK)
//   HEAD, TAIL      emit header / trailer around the shift
//   NBITS           shift length minus one (clamped to MAXLEN-1)
//   SEL[NCH]        channels receiving TCK
//   TDI_DATA        shift-out data, LSB first
//   TDO_IN[NCH]     per-channel TDO
//   TCK[NCH], TMS, TDI  JTAG outputs
//   BUSY, DONE      operation in progress / one-cycle completion pulse
//   TDO_DATA        captured TDO bits
// Optional feature: define FEBJTAG_READBACK_EN to build the TDO capture
// path; without it TDO_DATA is tied to zero and TDO_IN is ignored.
// ---------------------------------------------------------------------------
module febjtag_gen
    import febjtag_pkg::*;
#(
    parameter int NCH      = 5,
    parameter int MAXLEN   = 16,
    parameter int TCK_HALF = 1
) (
    input  logic                        CLK,
    input  logic                        RST_B,
    input  logic                        START,
    input  logic [1:0]                  MODE,
    input  logic                        HEAD,
    input  logic                        TAIL,
    input  logic [$clog2(MAXLEN)-1:0]   NBITS,
    input  logic [NCH-1:0]              SEL,
    input  logic [MAXLEN-1:0]           TDI_DATA,
    input  logic [NCH-1:0]              TDO_IN,
    output logic [NCH-1:0]              TCK,
    output logic                        TMS,
    output logic                        TDI,
    output logic                        BUSY,
    output logic                        DONE,
    output logic [MAXLEN-1:0]           TDO_DATA
);

    // Pulse index must reach MAXLEN-1 and also count the 6-pulse TAP reset
    localparam int STEP_W = ($clog2(MAXLEN) > 3) ? $clog2(MAXLEN) : 3;

    state_t              state;
    state_t              nxt_state;
    state_t              start_state;
    logic [STEP_W-1:0]   step;
    logic [STEP_W-1:0]   nxt_step;
    logic [STEP_W-1:0]   last_idx;
    logic [STEP_W-1:0]   start_lidx;
    logic                pulse_last;
    logic                instr_l;
    logic                tail_l;
    logic [MAXLEN-1:0]   data_l;
    logic [NCH-1:0]      sel_l;
    logic                tms_q;
    logic                tdi_q;
    logic                busy_q;
    logic                done_q;
    logic                run_q;
    logic                start_armed;
    logic                accept;
    logic                tck_int;
    logic                rise;
    logic                fall;

    // TMS value for pulse idx of a pulse-emitting state
    function automatic logic pulse_tms(input state_t st, input logic [STEP_W-1:0] idx,
                                       input logic instr, input logic tail,
                                       input logic [STEP_W-1:0] lidx);
        logic v;
        v = 1'b0;
        case (st)
            ST_HEAD:  v = instr ? pat_bit(8'(HDR_INSTR_TMS), 8'(idx))
                                : pat_bit(8'(HDR_DATA_TMS), 8'(idx));
            ST_SHIFT: v = (idx == lidx) ? tail : 1'b0;
            ST_TAIL:  v = pat_bit(8'(TRL_TMS), 8'(idx));
            ST_TRST:  v = pat_bit(8'(TRST_TMS), 8'(idx));
            default:  v = 1'b0;
        endcase
        return v;
    endfunction

    // TDI carries data only during the shift; everything else drives zero
    function automatic logic pulse_tdi(input state_t st, input logic [STEP_W-1:0] idx,
                                       input logic [MAXLEN-1:0] data);
        logic [MAXLEN-1:0] shifted;
        shifted = data >> idx;
        return (st == ST_SHIFT) ? shifted[0] : 1'b0;
    endfunction

    febjtag_tck_div #(
        .TCK_HALF (TCK_HALF)
    ) u_tck_div (
        .CLK   (CLK),
        .RST_B (RST_B),
        .RUN   (run_q),
        .TCK   (tck_int),
        .RISE  (rise),
        .FALL  (fall)
    );

    // start_armed blocks a START on the first edge after reset release
    assign accept = START & start_armed & ~busy_q;

    // First state and clamped shift length for a request being accepted
    always_comb begin
        if (int'(NBITS) >= MAXLEN - 1) begin
            start_lidx = STEP_W'(MAXLEN - 1);
        end else begin
            start_lidx = STEP_W'(NBITS);
        end
        if (MODE == MODE_TRST) begin
            start_state = ST_TRST;
        end else if (MODE == MODE_RSVD) begin
            start_state = ST_NOP;
        end else if (HEAD) begin
            start_state = ST_HEAD;
        end else begin
            start_state = ST_SHIFT;
        end
    end

    // Where the sequencer goes after the current pulse finishes
    always_comb begin
        pulse_last = 1'b0;
        nxt_state  = state;
        case (state)
            ST_HEAD: begin
                if (step == STEP_W'(HDR_LEN - 1)) begin
                    pulse_last = 1'b1;
                    nxt_state  = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (step == last_idx) begin
                    pulse_last = 1'b1;
                    nxt_state  = tail_l ? ST_TAIL : ST_FIN;
                end
            end
            ST_TAIL: begin
                if (step == STEP_W'(TRL_LEN - 1)) begin
                    pulse_last = 1'b1;
                    nxt_state  = ST_FIN;
                end
            end
            ST_TRST: begin
                if (step == STEP_W'(TRST_LEN - 1)) begin
                    pulse_last = 1'b1;
                    nxt_state  = ST_FIN;
                end
            end
            default: begin
            end
        endcase
        nxt_step = pulse_last ? '0 : step + 1'b1;
    end

    // Sequencer. TMS/TDI are updated on the edge that drops TCK, so they
    // only change while TCK is low. The last falling edge lands in FIN,
    // which is the DONE cycle; FIN is not busy and can accept a new START.
    always_ff @(posedge CLK or negedge RST_B) begin
        if (!RST_B) begin
            state       <= ST_IDLE;
            step        <= '0;
            last_idx    <= '0;
            instr_l     <= 1'b0;
            tail_l      <= 1'b0;
            data_l      <= '0;
            sel_l       <= '0;
            tms_q       <= 1'b0;
            tdi_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            run_q       <= 1'b0;
            start_armed <= 1'b0;
        end else begin
            start_armed <= 1'b1;
            done_q      <= 1'b0;
            if (accept) begin
                state    <= start_state;
                step     <= '0;
                last_idx <= start_lidx;
                instr_l  <= (MODE == MODE_INSTR);
                tail_l   <= TAIL;
                data_l   <= TDI_DATA;
                sel_l    <= SEL;
                busy_q   <= 1'b1;
                run_q    <= (start_state != ST_NOP);
                tms_q    <= pulse_tms(start_state, '0, (MODE == MODE_INSTR), TAIL, start_lidx);
                tdi_q    <= pulse_tdi(start_state, '0, TDI_DATA);
            end else begin
                case (state)
                    ST_FIN: begin
                        state <= ST_IDLE;
                    end
                    ST_NOP: begin
                        state  <= ST_FIN;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                    end
                    ST_HEAD, ST_SHIFT, ST_TAIL, ST_TRST: begin
                        if (fall) begin
                            state <= nxt_state;
                            step  <= nxt_step;
                            if (nxt_state == ST_FIN) begin
                                run_q  <= 1'b0;
                                busy_q <= 1'b0;
                                done_q <= 1'b1;
                                tms_q  <= 1'b0;
                                tdi_q  <= 1'b0;
                            end else begin
                                tms_q <= pulse_tms(nxt_state, nxt_step, instr_l, tail_l, last_idx);
                                tdi_q <= pulse_tdi(nxt_state, nxt_step, data_l);
                            end
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign TCK  = {NCH{tck_int}} & sel_l;
    assign TMS  = tms_q;
    assign TDI  = tdi_q;
    assign BUSY = busy_q;
    assign DONE = done_q;

`ifdef FEBJTAG_READBACK_EN
    logic              tdo_bit;
    logic [MAXLEN-1:0] start_keep;
    logic [MAXLEN-1:0] tdo_q;

    // Lowest-indexed selected channel drives the capture; no selection reads 0
    always_comb begin
        tdo_bit = 1'b0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (sel_l[i]) begin
                tdo_bit = TDO_IN[i];
            end
        end
    end

    // Bits 0..start_lidx survive the START clear; they are rewritten by the shift
    assign start_keep = (MAXLEN'(2) << start_lidx) - MAXLEN'(1);

    // Capture on the CLK edge that raises TCK, shift phase only
    always_ff @(posedge CLK or negedge RST_B) begin
        if (!RST_B) begin
            tdo_q <= '0;
        end else if (accept) begin
            tdo_q <= tdo_q & start_keep;
        end else if (state == ST_SHIFT && rise) begin
            tdo_q <= (tdo_q & ~(MAXLEN'(1) << step)) | (MAXLEN'(tdo_bit) << step);
        end
    end

    assign TDO_DATA = tdo_q;
`else
    logic unused_readback;
    assign unused_readback = ^{TDO_IN, rise};
    assign TDO_DATA = '0;
`endif

endmodule
